// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing with a req/ack output handshake.
// Define UART_RX_SYNC_EN to insert a two-flop synchronizer on the rx line.
module uart_rx #(
  parameter int SAMPLE         = 16,
  parameter int DATA_SIZE      = 8,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 en_sample,
  input  logic                 rx,
  input  logic                 recv_ack,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 recv_req,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(SAMPLE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CW-1:0] HALF_M1 = CW'(SAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(SAMPLE - 1);
  localparam logic [BIT_COUNT_SIZE-1:0] LAST =
    BIT_COUNT_SIZE'(DATA_SIZE - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BIT_COUNT_SIZE-1:0] bit_q, bit_d;
  logic [DATA_SIZE-1:0]      shift_q, shift_d;
  logic [DATA_SIZE-1:0]      dout_q, dout_d;
  logic                      req_q, req_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic                      done;
  logic                      take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else if (en_sample) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_SIZE-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completing word wins over an ack in the same cycle.
  always_comb begin
    take   = req_q & recv_ack;
    dout_d = dout_q;
    req_d  = req_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (done) begin
      dout_d = shift_q;
      ferr_d = ~rx_s;
      req_d  = 1'b1;
      ovr_d  = (req_q & ~recv_ack) | (ovr_q & ~take);
    end else if (take) begin
      req_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign recv_req  = req_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model compared every cycle plus directed checks.
// Tick every second clk, so one bit period is 32 clk.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int SAMPLE = 16;
  localparam int DW     = 8;
  localparam int BITCLK = 2 * SAMPLE;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 307;
`else
  localparam int LAT = 305;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b1;
  logic          en_sample = 1'b0;
  logic          rx = 1'b1;
  logic          recv_ack = 1'b0;
  logic [DW-1:0] dout;
  logic          recv_req;
  logic          frame_err;
  logic          overrun;

  uart_rx #(.SAMPLE(SAMPLE), .DATA_SIZE(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .en_sample (en_sample),
    .rx        (rx),
    .recv_ack  (recv_ack),
    .dout      (dout),
    .recv_req  (recv_req),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Frame-level model: sample points are fixed tick offsets from start detection.
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] m_word = '0;
  logic          m_req = 1'b0;
  logic          m_ferr = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_active = 1'b0;
  int            m_rel = 0;
`ifdef UART_RX_SYNC_EN
  logic          m_s1 = 1'b1;
  logic          m_s2 = 1'b1;
`endif

  initial begin : model
    logic rs;
    logic done;
    logic nf;
    int   k;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_dout = '0; m_word = '0; m_req = 0; m_ferr = 0;
        m_ovr = 0; m_active = 0; m_rel = 0;
`ifdef UART_RX_SYNC_EN
        m_s1 = 1; m_s2 = 1;
`endif
      end else begin
`ifdef UART_RX_SYNC_EN
        rs = m_s2; m_s2 = m_s1; m_s1 = rx;
`else
        rs = rx;
`endif
        done = 0;
        nf = 0;
        if (!en) m_active = 0;
        else if (en_sample) begin
          if (!m_active) begin
            if (!rs) begin m_active = 1; m_rel = 0; end
          end else begin
            m_rel++;
            if (m_rel == SAMPLE/2) begin
              if (rs) m_active = 0;
            end else if (m_rel > SAMPLE/2 &&
                         (m_rel - SAMPLE/2) % SAMPLE == 0) begin
              k = (m_rel - SAMPLE/2) / SAMPLE;
              if (k <= DW) m_word[k-1] = rs;
              else begin done = 1; nf = ~rs; m_active = 0; end
            end
          end
        end
        if (done) begin
          if (m_req && !recv_ack) m_ovr = 1;
          else if (m_req && recv_ack) m_ovr = 0;
          m_dout = m_word; m_ferr = nf; m_req = 1;
        end else if (m_req && recv_ack) begin
          m_req = 0; m_ovr = 0;
        end
      end
    end
  end

  int  rise_cyc = 0;
  int  hi_cnt = 0;
  int  last_len = 0;
  logic prev_req = 1'b0;

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("dout", dout, m_dout);
      chk("recv_req", recv_req, m_req);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      if (recv_req && !prev_req) rise_cyc = cyc;
      if (recv_req) hi_cnt++;
      else begin
        if (prev_req) last_len = hi_cnt;
        hi_cnt = 0;
      end
      prev_req = recv_req;
    end
  end

  int fall_cyc = 0;

  task automatic step();
    @(negedge clk);
    en_sample = ~en_sample;
  endtask

  task automatic hold(logic b, int n);
    repeat (n) begin step(); rx = b; end
  endtask

  // Start bit lands on a clk whose next rising edge is a tick.
  task automatic start_bit();
    if (en_sample) step();
    step();
    rx = 1'b0;
    fall_cyc = cyc;
    hold(1'b0, BITCLK - 1);
  endtask

  task automatic send_frame(logic [DW-1:0] d, logic stop);
    start_bit();
    for (int i = 0; i < DW; i++) hold(d[i], BITCLK);
    hold(stop, BITCLK);
  endtask

  task automatic ack_pulse();
    recv_ack = 1'b1;
    step();
    recv_ack = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] b5a;
    b5a = 8'h5A;
    repeat (4) step();
    chk("rst_dout", dout, 0);
    chk("rst_req", recv_req, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    hold(1'b1, 10);

    fork
      send_frame(8'hA5, 1'b1);
      begin : acker
        int w;
        w = 0;
        while (!recv_req && w < 2000) begin @(negedge clk); w++; end
        chk("a5_req_seen", recv_req, 1);
        repeat (3) @(negedge clk);
        recv_ack = 1'b1;
        @(negedge clk);
        recv_ack = 1'b0;
      end
    join
    hold(1'b1, 20);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_ferr", frame_err, 0);
    chk("a5_req_after_ack", recv_req, 0);
    chk("a5_req_len", last_len, 4);
    chk("a5_latency", rise_cyc - fall_cyc, LAT);

    start_bit_short();
    hold(1'b1, 64);
    chk("false_req", recv_req, 0);
    chk("false_dout", dout, 8'hA5);

    send_frame(8'h3C, 1'b0);
    hold(1'b1, 64);
    chk("3c_dout", dout, 8'h3C);
    chk("3c_ferr", frame_err, 1);
    chk("3c_req", recv_req, 1);
    chk("3c_ovr", overrun, 0);

    en = 1'b0;
    hold(1'b1, 4);
    ack_pulse();
    chk("en0_ack_req", recv_req, 0);
    chk("en0_keep_dout", dout, 8'h3C);
    chk("en0_keep_ferr", frame_err, 1);
    send_frame(8'h66, 1'b1);
    hold(1'b1, 10);
    chk("en0_no_rx", recv_req, 0);
    en = 1'b1;
    hold(1'b1, 10);

    start_bit();
    hold(1'b0, BITCLK);
    en = 1'b0;
    hold(1'b0, 4);
    en = 1'b1;
    hold(1'b1, 400);
    chk("en_abort_req", recv_req, 0);

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 20);
    chk("b2b_dout", dout, 8'h22);
    chk("b2b_ovr", overrun, 1);
    chk("b2b_req", recv_req, 1);
    ack_pulse();
    chk("b2b_ack_req", recv_req, 0);
    chk("b2b_ack_ovr", overrun, 0);

    start_bit();
    for (int i = 0; i < 4; i++) hold(b5a[i], BITCLK);
    hold(b5a[4], BITCLK / 2);
    reset_n = 1'b0;
    rx = 1'b1;
    step();
    step();
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_req", recv_req, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    reset_n = 1'b1;
    hold(1'b1, 20);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 20);
    chk("81_dout", dout, 8'h81);
    chk("81_req", recv_req, 1);
    chk("81_ferr", frame_err, 0);
    chk("81_ovr", overrun, 0);

    fork
      send_frame(8'h42, 1'b1);
      begin : coinc_ack
        int w;
        w = 0;
        repeat (4) @(negedge clk);
        while (cyc < fall_cyc + LAT - 1 && w < 2000) begin
          @(negedge clk); w++;
        end
        recv_ack = 1'b1;
        @(negedge clk);
        recv_ack = 1'b0;
      end
    join
    hold(1'b1, 20);
    chk("42_dout", dout, 8'h42);
    chk("42_req", recv_req, 1);
    chk("42_ovr", overrun, 0);
    ack_pulse();
    chk("42_ack_req", recv_req, 0);

    hold(1'b1, 10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  task automatic start_bit_short();
    if (en_sample) step();
    step();
    rx = 1'b0;
    hold(1'b0, 7);
  endtask

endmodule
